regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the pipelined core: N_READ combinational read ports, two synchronous write ports (ALU result and load/writeback), optional same-cycle write-to-read forwarding, and a per-register pending-write scoreboard for hazard detection. The program counter is not stored; reads of PC_IDX return the external R15 value. It sits between the decode stage (read/issue) and the writeback stage (write/retire).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; register count is 2**ADDR_W, including the PC slot
- N_READ, 3, number of read ports (at least 1)
- PC_IDX, 15, address redirected to the R15 input
- BYPASS, 1, 1 enables same-cycle write-to-read forwarding; 0 disables it

- CLK  in  1  rising-edge clock
- RESETn  in  1  asynchronous, active-low reset
- RA  in  N_READ*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- RD  out  N_READ*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- BUSY  out  N_READ  1 when port i's register has an outstanding write
- R15  in  DATA_W  current PC+8 value, supplied externally
- WE3, A3, WD3  in  1/ADDR_W/DATA_W  write port A (ALU writeback)
- WE4, A4, WD4  in  1/ADDR_W/DATA_W  write port B (load/base writeback)
- SET_EN, SET_A  in  1/ADDR_W  issue: mark register SET_A pending

## Operation
- Storage holds 2**ADDR_W-1 data words; slot PC_IDX has no storage.
- Read port i:
  - RA_i == PC_IDX -> R15.
  - Otherwise, if BYPASS=1 and WE4 && A4 == RA_i -> WD4.
  - Otherwise, if BYPASS=1 and WE3 && A3 == RA_i -> WD3.
  - Otherwise the stored value.
- Writes take effect on the rising edge. When WE3 and WE4 target the same address, WD4 wins, and the forwarding priority matches.
- Writes to PC_IDX are discarded without error.
- Scoreboard: one busy bit per non-PC register.
  - SET_EN sets the bit for SET_A.
  - A write on either port clears the bit for its address.
  - If a set and a clear hit the same register in the same cycle, the set wins: it is a newer issue.
  - SET_A == PC_IDX is ignored.
- BUSY_i is the registered busy bit for RA_i, with these exceptions:
  - It is 0 when RA_i == PC_IDX.
  - When BYPASS=1, it is masked to 0 if a write to RA_i is presented in the same cycle.
- Reset (RESETn low, asynchronous): all stored registers = 0 and all busy bits = 0.
  - While reset is held, RD_i = 0 for non-PC addresses and R15 for PC_IDX; BUSY = 0.
  - Writes and sets are ignored during reset.
  - Reset asserted mid-operation discards pending writes immediately.

## Timing
- Read latency is 0 cycles (combinational from RA, R15, and, when BYPASS=1, the write ports).
- Write latency is 1 cycle. With BYPASS=0, a write in cycle n is visible on RD in cycle n+1. With BYPASS=1 it is visible in cycle n.
- Scoreboard updates are registered: a SET_EN in cycle n shows as BUSY in cycle n+1.
- There are no combinational paths from SET_EN/SET_A to any output.
- Reset deassertion is synchronised externally. The first write is accepted on the first rising edge with RESETn high.

## Structure
- Package regfile_pkg holds the default constants (DATA_W, ADDR_W, PC_IDX) and a function that computes the number of stored registers.
- Sub-module regfile_scoreboard contains the busy-bit array, the set/clear priority logic and the per-port BUSY lookup. Its parameters are ADDR_W, N_READ and PC_IDX. It takes the write-port strobes as clear inputs.
- The read mux and forwarding use a generate loop over N_READ.

## Test plan
- Reset, then read all 16 addresses with R15=0x0000_0108: required RD = 0 for r0–r14, and 0x108 for r15; BUSY = 0.
- Write r3=0xDEAD_BEEF via port A and read r3 in the same cycle: BYPASS=1 returns 0xDEADBEEF in that cycle; BYPASS=0 returns 0 in that cycle and 0xDEADBEEF in the next.
- Same-cycle WE3 r5=0x11 and WE4 r5=0x22: the next-cycle read of r5 returns 0x22. Then write r15=0x55 and read r15 with R15=0x200: returns 0x200, and no stored register changes.
- SET_EN r7, then two cycles later write r7=0x77 via port B: BUSY is 1 for r7 from cycle 1 until the write; at the write cycle with BYPASS=1, BUSY=0 and RD=0x77. With SET_EN r7 and WE3 r7 in the same cycle, BUSY for r7 is 1 in the next cycle.
- Mid-run, set r1..r4 busy, write nonzero values, then pulse RESETn low between clock edges: RD and BUSY drop to 0 immediately, without waiting for a clock edge.
- Instantiate N_READ=4, DATA_W=16 and read four different registers concurrently: each port returns its own 16-bit value.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults for the multi-port register file.
//   DefDataW / DefAddrW / DefPcIdx - default register width, address width and PC slot.
//   num_stored()                   - number of data words actually held (PC slot excluded).
package regfile_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefPcIdx = 15;

    // The PC slot is an alias of an external input, so it carries no storage.
    function automatic int unsigned num_stored(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits for hazard detection.
//   clk_i, rst_ni        - clock, asynchronous active-low reset
//   set_en_i, set_a_i    - issue: mark set_a_i pending
//   clr3_i/clr3_a_i      - write port A strobe/address (clears pending bit)
//   clr4_i/clr4_a_i      - write port B strobe/address (clears pending bit)
//   ra_i                 - packed read addresses, one per port
//   busy_o               - registered pending bit for each read address (0 for the PC slot)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned N_READ = 3,
    parameter int unsigned PC_IDX = DefPcIdx
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       set_en_i,
    input  logic [ADDR_W-1:0]          set_a_i,
    input  logic                       clr3_i,
    input  logic [ADDR_W-1:0]          clr3_a_i,
    input  logic                       clr4_i,
    input  logic [ADDR_W-1:0]          clr4_a_i,
    input  logic [N_READ*ADDR_W-1:0]   ra_i,
    output logic [N_READ-1:0]          busy_o
);

    localparam int unsigned        NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0]  PcAddr  = ADDR_W'(PC_IDX);

    logic [NumRegs-1:0] busy_q, busy_d;

    // Set is applied last so a same-cycle issue beats the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (clr3_i) busy_d[clr3_a_i] = 1'b0;
        if (clr4_i) busy_d[clr4_a_i] = 1'b0;
        if (set_en_i && (set_a_i != PcAddr)) busy_d[set_a_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < N_READ; g++) begin : g_lookup
        logic [ADDR_W-1:0] ra;
        assign ra        = ra_i[g*ADDR_W +: ADDR_W];
        assign busy_o[g] = (ra != PcAddr) && busy_q[ra];
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, optional write-to-read
// forwarding and a pending-write scoreboard.
//   clk_i, rst_ni               - clock, asynchronous active-low reset
//   ra_i / rd_o                 - packed read addresses / combinational read data
//   busy_o                      - per-port pending-write flag
//   r15_i                       - external PC+8 value returned for reads of PC_IDX
//   we3_i, a3_i, wd3_i          - write port A (ALU writeback)
//   we4_i, a4_i, wd4_i          - write port B (load/base writeback), wins over port A
//   set_en_i, set_a_i           - issue: mark a register pending
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned N_READ = 3,
    parameter int unsigned PC_IDX = DefPcIdx,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_READ*ADDR_W-1:0]   ra_i,
    output logic [N_READ*DATA_W-1:0]   rd_o,
    output logic [N_READ-1:0]          busy_o,
    input  logic [DATA_W-1:0]          r15_i,
    input  logic                       we3_i,
    input  logic [ADDR_W-1:0]          a3_i,
    input  logic [DATA_W-1:0]          wd3_i,
    input  logic                       we4_i,
    input  logic [ADDR_W-1:0]          a4_i,
    input  logic [DATA_W-1:0]          wd4_i,
    input  logic                       set_en_i,
    input  logic [ADDR_W-1:0]          set_a_i
);

    localparam int unsigned       NumStored = num_stored(ADDR_W);
    localparam logic [ADDR_W-1:0] PcAddr    = ADDR_W'(PC_IDX);

    // Addresses above the PC slot shift down one so storage stays dense.
    function automatic logic [ADDR_W-1:0] slot_of(input logic [ADDR_W-1:0] a);
        return (a > PcAddr) ? (a - ADDR_W'(1)) : a;
    endfunction

    logic [DATA_W-1:0] mem_q [NumStored];
    logic [DATA_W-1:0] mem_d [NumStored];
    logic [N_READ-1:0] sb_busy;

    // Port B is applied after port A so it wins on an address collision.
    always_comb begin
        mem_d = mem_q;
        if (we3_i && (a3_i != PcAddr)) mem_d[slot_of(a3_i)] = wd3_i;
        if (we4_i && (a4_i != PcAddr)) mem_d[slot_of(a4_i)] = wd4_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumStored; s++) mem_q[s] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_READ (N_READ),
        .PC_IDX (PC_IDX)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_en_i (set_en_i),
        .set_a_i  (set_a_i),
        .clr3_i   (we3_i),
        .clr3_a_i (a3_i),
        .clr4_i   (we4_i),
        .clr4_a_i (a4_i),
        .ra_i     (ra_i),
        .busy_o   (sb_busy)
    );

    for (genvar g = 0; g < N_READ; g++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              hit3, hit4;

        assign ra   = ra_i[g*ADDR_W +: ADDR_W];
        assign hit3 = BYPASS && we3_i && (a3_i == ra);
        assign hit4 = BYPASS && we4_i && (a4_i == ra);

        // Reset gates the forwarding path too, so held-reset reads see zeros.
        always_comb begin
            if (ra == PcAddr) begin
                rd = r15_i;
            end else if (!rst_ni) begin
                rd = '0;
            end else if (hit4) begin
                rd = wd4_i;
            end else if (hit3) begin
                rd = wd3_i;
            end else begin
                rd = mem_q[slot_of(ra)];
            end
        end

        assign rd_o[g*DATA_W +: DATA_W] = rd;
        // A write presented this cycle is already visible via forwarding.
        assign busy_o[g] = sb_busy[g] & ~(hit3 | hit4);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (BYPASS=1, BYPASS=0 and a
// 4-port 16-bit instance).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ra;
    logic [95:0] rd, rd_nb;
    logic [2:0]  busy, busy_nb;
    logic [31:0] r15, wd3, wd4;
    logic        we3, we4, set_en;
    logic [3:0]  a3, a4, set_a;

    logic [15:0] ra4;
    logic [63:0] rd4;
    logic [3:0]  busy4;
    logic [15:0] r15_4, wd3_4, wd4_4;
    logic        we3_4, we4_4;
    logic [3:0]  a3_4, a4_4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ra_i(ra), .rd_o(rd), .busy_o(busy), .r15_i(r15),
        .we3_i(we3), .a3_i(a3), .wd3_i(wd3), .we4_i(we4), .a4_i(a4), .wd4_i(wd4),
        .set_en_i(set_en), .set_a_i(set_a)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .ra_i(ra), .rd_o(rd_nb), .busy_o(busy_nb), .r15_i(r15),
        .we3_i(we3), .a3_i(a3), .wd3_i(wd3), .we4_i(we4), .a4_i(a4), .wd4_i(wd4),
        .set_en_i(set_en), .set_a_i(set_a)
    );

    regfile_mp #(.DATA_W(16), .N_READ(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .ra_i(ra4), .rd_o(rd4), .busy_o(busy4), .r15_i(r15_4),
        .we3_i(we3_4), .a3_i(a3_4), .wd3_i(wd3_4), .we4_i(we4_4), .a4_i(a4_4), .wd4_i(wd4_4),
        .set_en_i(1'b0), .set_a_i(4'd0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst_n = 1'b0;
        r15   = 32'h0000_0108;
        for (int a = 0; a < 16; a++) begin
            ra  = {3{4'(a)}};
            exp = (a == 15) ? 32'h108 : 32'h0;
            #1;
            checks++;
            if (rd[31:0] !== exp || rd_nb[95:64] !== exp) begin
                errors++;
                $display("FAIL reset_rd r%0d got %h/%h exp %h", a, rd[31:0], rd_nb[95:64], exp);
            end
            checks++;
            if (busy !== 3'b000 || busy_nb !== 3'b000) begin
                errors++;
                $display("FAIL reset_busy r%0d got %b/%b exp 000", a, busy, busy_nb);
            end
        end
        // Writes and sets while reset is held must be ignored, including forwarding.
        ra = 12'h000; we3 = 1'b1; a3 = 4'd0; wd3 = 32'hFF; set_en = 1'b1; set_a = 4'd0;
        #1;
        checks++;
        if (rd[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_fwd got %h exp 0", rd[31:0]);
        end
        step();
        we3 = 1'b0; set_en = 1'b0; rst_n = 1'b1;
        #1;
        checks++;
        if (rd[31:0] !== 32'h0 || rd_nb[31:0] !== 32'h0 || busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_ignore got %h/%h busy %b exp 0/0 busy 000",
                     rd[31:0], rd_nb[31:0], busy);
        end
    endtask

    task automatic test_bypass();
        ra = {3{4'd3}}; we3 = 1'b1; a3 = 4'd3; wd3 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (rd[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_same got %h exp deadbeef", rd[31:0]);
        end
        checks++;
        if (rd_nb[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_same got %h exp 0", rd_nb[31:0]);
        end
        step();
        we3 = 1'b0;
        #1;
        checks++;
        if (rd[31:0] !== 32'hDEAD_BEEF || rd_nb[31:0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_next got %h/%h exp deadbeef", rd[31:0], rd_nb[31:0]);
        end
    endtask

    task automatic test_dual_write();
        ra = {3{4'd5}};
        we3 = 1'b1; a3 = 4'd5; wd3 = 32'h11;
        we4 = 1'b1; a4 = 4'd5; wd4 = 32'h22;
        #1;
        checks++;
        if (rd[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL fwd_priority got %h exp 22", rd[31:0]);
        end
        step();
        we3 = 1'b0; we4 = 1'b0;
        #1;
        checks++;
        if (rd[31:0] !== 32'h22 || rd_nb[31:0] !== 32'h22) begin
            errors++;
            $display("FAIL write_priority got %h/%h exp 22", rd[31:0], rd_nb[31:0]);
        end
        // PC writes are discarded; reads of PC_IDX follow R15.
        r15 = 32'h200; ra = {3{4'd15}};
        we3 = 1'b1; a3 = 4'd15; wd3 = 32'h55;
        we4 = 1'b1; a4 = 4'd15; wd4 = 32'h55;
        #1;
        checks++;
        if (rd[31:0] !== 32'h200) begin
            errors++;
            $display("FAIL pc_read_same got %h exp 200", rd[31:0]);
        end
        step();
        we3 = 1'b0; we4 = 1'b0;
        #1;
        checks++;
        if (rd[31:0] !== 32'h200 || rd_nb[31:0] !== 32'h200) begin
            errors++;
            $display("FAIL pc_read_next got %h/%h exp 200", rd[31:0], rd_nb[31:0]);
        end
        ra = {4'd14, 4'd5, 4'd3};
        #1;
        checks++;
        if (rd !== {32'h0, 32'h22, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL pc_no_side_effect got %h exp %h", rd, {32'h0, 32'h22, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_scoreboard();
        ra = {3{4'd7}}; set_en = 1'b1; set_a = 4'd7;
        #1;
        checks++;
        if (busy !== 3'b000) begin
            errors++;
            $display("FAIL set_no_comb got %b exp 000", busy);
        end
        step();
        set_en = 1'b0;
        #1;
        checks++;
        if (busy !== 3'b111 || busy_nb !== 3'b111) begin
            errors++;
            $display("FAIL busy_c1 got %b/%b exp 111", busy, busy_nb);
        end
        we4 = 1'b1; a4 = 4'd7; wd4 = 32'h77;
        #1;
        checks++;
        if (busy !== 3'b000 || rd[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL busy_mask got busy %b rd %h exp busy 000 rd 77", busy, rd[31:0]);
        end
        checks++;
        if (busy_nb !== 3'b111 || rd_nb[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL nb_busy_write got busy %b rd %h exp busy 111 rd 0", busy_nb, rd_nb[31:0]);
        end
        step();
        we4 = 1'b0;
        #1;
        checks++;
        if (busy !== 3'b000 || busy_nb !== 3'b000 || rd_nb[31:0] !== 32'h77) begin
            errors++;
            $display("FAIL busy_clear got %b/%b rd %h exp 000/000 rd 77", busy, busy_nb, rd_nb[31:0]);
        end
        // Set and clear on the same register: set wins.
        set_en = 1'b1; set_a = 4'd7; we3 = 1'b1; a3 = 4'd7; wd3 = 32'h78;
        step();
        set_en = 1'b0; we3 = 1'b0;
        #1;
        checks++;
        if (busy !== 3'b111 || busy_nb !== 3'b111 || rd[31:0] !== 32'h78) begin
            errors++;
            $display("FAIL set_wins got %b/%b rd %h exp 111/111 rd 78", busy, busy_nb, rd[31:0]);
        end
        we3 = 1'b1;
        step();
        we3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 4; i++) begin
            we3 = 1'b1; a3 = 4'(i); wd3 = 32'h100 + 32'(i);
            step();
        end
        we3 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_en = 1'b1; set_a = 4'(i);
            step();
        end
        set_en = 1'b0;
        ra = {4'd3, 4'd2, 4'd1};
        #1;
        checks++;
        if (rd !== {32'h103, 32'h102, 32'h101} || busy !== 3'b111) begin
            errors++;
            $display("FAIL mid_before got %h busy %b exp 103/102/101 busy 111", rd, busy);
        end
        we4 = 1'b1; a4 = 4'd4; wd4 = 32'hAAAA;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd !== 96'h0 || busy !== 3'b000 || rd_nb !== 96'h0 || busy_nb !== 3'b000) begin
            errors++;
            $display("FAIL mid_async got %h busy %b / %h busy %b exp 0", rd, busy, rd_nb, busy_nb);
        end
        ra = {4'd4, 4'd15, 4'd4};
        #1;
        checks++;
        if (rd !== {32'h0, 32'h200, 32'h0}) begin
            errors++;
            $display("FAIL mid_hold got %h exp %h", rd, {32'h0, 32'h200, 32'h0});
        end
        step();
        we4 = 1'b0; rst_n = 1'b1;
        #1;
        checks++;
        if (rd[31:0] !== 32'h0 || rd_nb[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_discard got %h/%h exp 0", rd[31:0], rd_nb[31:0]);
        end
    endtask

    task automatic test_wide();
        we3_4 = 1'b1; a3_4 = 4'd2;  wd3_4 = 16'h1111;
        we4_4 = 1'b1; a4_4 = 4'd6;  wd4_4 = 16'h2222;
        step();
        a3_4 = 4'd9; wd3_4 = 16'h3333;
        a4_4 = 4'd12; wd4_4 = 16'h4444;
        step();
        we3_4 = 1'b0; we4_4 = 1'b0;
        ra4 = {4'd12, 4'd9, 4'd6, 4'd2};
        #1;
        checks++;
        if (rd4[15:0] !== 16'h1111) begin
            errors++;
            $display("FAIL wide_p0 got %h exp 1111", rd4[15:0]);
        end
        checks++;
        if (rd4[31:16] !== 16'h2222) begin
            errors++;
            $display("FAIL wide_p1 got %h exp 2222", rd4[31:16]);
        end
        checks++;
        if (rd4[47:32] !== 16'h3333) begin
            errors++;
            $display("FAIL wide_p2 got %h exp 3333", rd4[47:32]);
        end
        checks++;
        if (rd4[63:48] !== 16'h4444 || busy4 !== 4'b0000) begin
            errors++;
            $display("FAIL wide_p3 got %h busy %b exp 4444 busy 0000", rd4[63:48], busy4);
        end
    endtask

    initial begin
        rst_n = 1'b0; ra = '0; r15 = '0;
        we3 = 1'b0; a3 = '0; wd3 = '0; we4 = 1'b0; a4 = '0; wd4 = '0;
        set_en = 1'b0; set_a = '0;
        ra4 = '0; r15_4 = 16'hF00D;
        we3_4 = 1'b0; a3_4 = '0; wd3_4 = '0; we4_4 = 1'b0; a4_4 = '0; wd4_4 = '0;
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_reset_mid();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
